// File: rtl/read_fmap_pkg.sv
// Shared definitions for the feature-pad read side: FSM encodings, credit
// limit and the address widths agreed with the fmap loader.
package read_fmap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        DRAIN = 2'b11
    } state_t;

    localparam int F_PAD_AW = 8;
    localparam int W_PAD_AW = 8;

    // Buffer occupancy plus reads in flight may never exceed this.
    localparam int CREDIT_LIMIT = 3;

endpackage

// File: rtl/read_fmap_fifo.sv
// Small show-ahead FIFO: head entry is visible on rdata while not empty,
// and reads as zero when empty.
module read_fmap_fifo
    import read_fmap_pkg::*;
#(
    parameter int DEPTH_WIDTH = 2,
    parameter int DATA_WIDTH  = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic [DEPTH_WIDTH:0]  count
);

    localparam int DEPTH = 1 << DEPTH_WIDTH;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_WIDTH-1:0] wr_ptr;
    logic [DEPTH_WIDTH-1:0] rd_ptr;
    logic                   full;
    logic                   do_push;
    logic                   do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (DEPTH_WIDTH+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/read_fmap.sv
// Feature scratch-pad reader: walks sliding windows (stride 1), issues pad
// reads under credit and writer gating, and streams tagged pixels to the PE.
module read_fmap
    import read_fmap_pkg::*;
#(
    parameter int DATA_WIDTH           = 16,
    parameter int ADDRESSWIDTH_F_PAD   = F_PAD_AW,
    parameter int ADDRESSWIDTH_W_PAD   = W_PAD_AW,
    parameter int OUT_FIFO_DEPTH_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          read_start,
    input  logic                          stream_mode,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] pixel_point,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] out_num,
    input  logic [ADDRESSWIDTH_W_PAD-1:0] weight_num,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]         pad_rdata,
    output logic [ADDRESSWIDTH_F_PAD-1:0] raddra_ifmap,
    output logic [DATA_WIDTH-1:0]         fmap_to_pe,
    output logic                          fmap_valid,
    input  logic                          pe_ready,
    output logic                          fmap_last_k,
    output logic                          fmap_last,
    output logic                          busy,
    output logic                          read_done
);

    localparam int AF = ADDRESSWIDTH_F_PAD;
    localparam int AW = ADDRESSWIDTH_W_PAD;
    localparam int CW = OUT_FIFO_DEPTH_WIDTH + 2;

    state_t state, state_nxt;

    logic [AF-1:0] pixel_point_q;
    logic [AF-1:0] out_num_q;
    logic [AW-1:0] weight_num_q;
    logic          stream_mode_q;
    logic [AF-1:0] o_cnt;
    logic [AW-1:0] k_cnt;

    logic [AF-1:0] rd_addr;
    logic          k_end;
    logic          o_end;
    logic          degen;
    logic          gate_ok;
    logic          credit_ok;
    logic          issue;
    logic          fire;
    logic [CW-1:0] credit_used;

    logic          vld_p0, last_k_p0, last_p0;
    logic          vld_p1, last_k_p1, last_p1;

    logic [DATA_WIDTH+1:0]         fifo_rdata;
    logic                          fifo_empty;
    logic [OUT_FIFO_DEPTH_WIDTH:0] fifo_count;

    assign rd_addr = pixel_point_q + o_cnt + AF'(k_cnt);
    assign k_end   = (k_cnt == weight_num_q - AW'(1));
    assign o_end   = (o_cnt == out_num_q - AF'(1));
    assign degen   = (out_num_q == '0) || (weight_num_q == '0);
    assign gate_ok = !stream_mode_q || (rd_addr < wr_addr);

    assign fmap_valid  = !fifo_empty;
    assign fire        = fmap_valid && pe_ready;
    assign fmap_to_pe  = fifo_rdata[DATA_WIDTH-1:0];
    assign fmap_last_k = fifo_rdata[DATA_WIDTH];
    assign fmap_last   = fifo_rdata[DATA_WIDTH+1];
    assign busy        = (state != IDLE);

    // A pop this cycle frees its slot before the new read can land.
    assign credit_used = CW'(fifo_count) + CW'(vld_p0) + CW'(vld_p1) - CW'(fire);
    assign credit_ok   = (credit_used < CW'(CREDIT_LIMIT));

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        read_done = 1'b0;
        case (state)
            IDLE: begin
                if (read_start) state_nxt = READ;
            end
            READ: begin
                if (degen) begin
                    read_done = 1'b1;
                    state_nxt = IDLE;
                end else if (credit_ok && gate_ok) begin
                    issue = 1'b1;
                    if (k_end && o_end) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fire && fmap_last) begin
                    read_done = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pixel_point_q <= '0;
            out_num_q     <= '0;
            weight_num_q  <= '0;
            stream_mode_q <= 1'b0;
            o_cnt         <= '0;
            k_cnt         <= '0;
            raddra_ifmap  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && read_start) begin
                pixel_point_q <= pixel_point;
                out_num_q     <= out_num;
                weight_num_q  <= weight_num;
                stream_mode_q <= stream_mode;
                o_cnt         <= '0;
                k_cnt         <= '0;
            end else if (issue) begin
                raddra_ifmap <= rd_addr;
                if (k_end) begin
                    k_cnt <= '0;
                    o_cnt <= o_cnt + 1'b1;
                end else begin
                    k_cnt <= k_cnt + 1'b1;
                end
            end
        end
    end

    // p0: address on the pad port; p1: pad_rdata valid, pushed next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0    <= 1'b0;
            last_k_p0 <= 1'b0;
            last_p0   <= 1'b0;
            vld_p1    <= 1'b0;
            last_k_p1 <= 1'b0;
            last_p1   <= 1'b0;
        end else begin
            vld_p0    <= issue;
            last_k_p0 <= issue && k_end;
            last_p0   <= issue && k_end && o_end;
            vld_p1    <= vld_p0;
            last_k_p1 <= last_k_p0;
            last_p1   <= last_p0;
        end
    end

    read_fmap_fifo #(
        .DEPTH_WIDTH (OUT_FIFO_DEPTH_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH + 2)
    ) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_p1),
        .wdata ({last_p1, last_k_p1, pad_rdata}),
        .pop   (fire),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_read_fmap.sv
// Directed bench for read_fmap with a registered pad model whose data word
// encodes the address it was read from.
module tb_read_fmap;

    logic        clk;
    logic        rst_n;
    logic        read_start;
    logic        stream_mode;
    logic [7:0]  pixel_point;
    logic [7:0]  out_num;
    logic [7:0]  weight_num;
    logic [7:0]  wr_addr;
    logic [15:0] pad_rdata;
    logic [7:0]  raddra_ifmap;
    logic [15:0] fmap_to_pe;
    logic        fmap_valid;
    logic        pe_ready;
    logic        fmap_last_k;
    logic        fmap_last;
    logic        busy;
    logic        read_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_addr[$];

    read_fmap dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_start   (read_start),
        .stream_mode  (stream_mode),
        .pixel_point  (pixel_point),
        .out_num      (out_num),
        .weight_num   (weight_num),
        .wr_addr      (wr_addr),
        .pad_rdata    (pad_rdata),
        .raddra_ifmap (raddra_ifmap),
        .fmap_to_pe   (fmap_to_pe),
        .fmap_valid   (fmap_valid),
        .pe_ready     (pe_ready),
        .fmap_last_k  (fmap_last_k),
        .fmap_last    (fmap_last),
        .busy         (busy),
        .read_done    (read_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) pad_rdata <= {8'hC3, raddra_ifmap};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after read_done.
    task automatic run_job(input string name, input logic [7:0] pp, input logic [7:0] on,
                           input logic [7:0] wn, input logic sm, input int mode,
                           input logic chk_lat, input logic glitch);
        int   beats = 0;
        int   first_v = -1;
        int   n = exp_addr.size();
        bit   done = 0;
        logic hold_pend = 0;
        logic [15:0] prev_data = '0;
        logic [1:0]  prev_tags = '0;
        pixel_point = pp;
        out_num     = on;
        weight_num  = wn;
        stream_mode = sm;
        read_start  = 1'b1;
        @(negedge clk);
        read_start = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            pe_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (sm && (cyc % 5 == 4) && wr_addr < 8'd255) wr_addr = wr_addr + 8'd1;
            if (glitch && cyc == 5) begin
                read_start  = 1'b1;
                pixel_point = 8'd100;
                weight_num  = 8'd1;
            end else if (glitch && cyc == 6) begin
                read_start = 1'b0;
            end
            #1;
            if (hold_pend) begin
                chk({name, ":hold_data"}, 32'(fmap_to_pe), 32'(prev_data));
                chk({name, ":hold_tags"}, 32'({fmap_valid, fmap_last, fmap_last_k}),
                    32'({1'b1, prev_tags}));
            end
            if (fmap_valid && first_v < 0) first_v = cyc;
            chk({name, ":read_done"}, 32'(read_done),
                32'(fmap_valid && pe_ready && beats == n - 1));
            if (fmap_valid && pe_ready) begin
                if (beats < n) begin
                    chk({name, ":data"}, 32'(fmap_to_pe), 32'({8'hC3, exp_addr[beats]}));
                    chk({name, ":last_k"}, 32'(fmap_last_k), 32'((beats + 1) % int'(wn) == 0));
                    chk({name, ":last"}, 32'(fmap_last), 32'(beats == n - 1));
                    if (sm) chk({name, ":gate"}, 32'(fmap_to_pe[7:0] < wr_addr), 32'd1);
                end else begin
                    chk({name, ":extra_beat"}, 32'(beats), 32'(n - 1));
                end
                beats++;
            end
            if (read_done) done = 1;
            hold_pend = fmap_valid && !pe_ready;
            prev_data = fmap_to_pe;
            prev_tags = {fmap_last, fmap_last_k};
            @(negedge clk);
        end
        chk({name, ":done"}, 32'(done), 32'd1);
        chk({name, ":beats"}, 32'(beats), 32'(n));
        chk({name, ":busy_after"}, 32'(busy), 32'd0);
        if (chk_lat) chk({name, ":latency"}, 32'(first_v), 32'd3);
        if (sm) chk({name, ":wr_addr_at_done"}, 32'(wr_addr >= 8'd5), 32'd1);
        pe_ready = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        read_start  = 1'b0;
        stream_mode = 1'b0;
        pixel_point = '0;
        out_num     = '0;
        weight_num  = '0;
        wr_addr     = '0;
        pe_ready    = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst:valid", 32'(fmap_valid), 32'd0);
        chk("rst:busy", 32'(busy), 32'd0);
        chk("rst:raddr", 32'(raddra_ifmap), 32'd0);
        chk("rst:data", 32'(fmap_to_pe), 32'd0);
        chk("rst:tags", 32'({fmap_last, fmap_last_k, read_done}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        exp_addr = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2, 8'd3, 8'd2, 8'd3, 8'd4};
        run_job("basic", 8'd0, 8'd3, 8'd3, 1'b0, 0, 1'b1, 1'b0);
        run_job("bp", 8'd0, 8'd3, 8'd3, 1'b0, 1, 1'b0, 1'b1);

        // Degenerate job: done straight away, no new read address.
        pixel_point = 8'd50;
        out_num     = 8'd3;
        weight_num  = 8'd0;
        read_start  = 1'b1;
        @(negedge clk);
        read_start = 1'b0;
        #1;
        chk("degen:read_done", 32'(read_done), 32'd1);
        chk("degen:busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("degen:read_done_after", 32'(read_done), 32'd0);
        chk("degen:busy_after", 32'(busy), 32'd0);
        chk("degen:raddr", 32'(raddra_ifmap), 32'd4);
        chk("degen:valid", 32'(fmap_valid), 32'd0);

        exp_addr = '{8'd254, 8'd255, 8'd255, 8'd0};
        run_job("wrap", 8'd254, 8'd2, 8'd2, 1'b0, 0, 1'b1, 1'b0);

        exp_addr = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2, 8'd3, 8'd2, 8'd3, 8'd4};
        wr_addr = 8'd2;
        run_job("stream", 8'd0, 8'd3, 8'd3, 1'b1, 0, 1'b0, 1'b0);

        // Reset in the middle of a READ phase.
        stream_mode = 1'b0;
        pixel_point = 8'd10;
        out_num     = 8'd4;
        weight_num  = 8'd4;
        read_start  = 1'b1;
        @(negedge clk);
        read_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst:busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst:valid", 32'(fmap_valid), 32'd0);
        chk("midrst:busy", 32'(busy), 32'd0);
        chk("midrst:raddr", 32'(raddra_ifmap), 32'd0);
        chk("midrst:data", 32'(fmap_to_pe), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midrst:no_done", 32'({busy, read_done}), 32'd0);
        end

        exp_addr = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2, 8'd3, 8'd2, 8'd3, 8'd4};
        run_job("after_rst", 8'd0, 8'd3, 8'd3, 1'b0, 0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/read_fmap.md
Name: read_fmap

Overview:
- Consumer end of the PE feature scratch pad. The fmap loader is the writer of that pad.
- Generates read addresses into the pad and captures the registered pad data, one cycle after the address.
- Streams pixels to the PE MAC in sliding-window order (stride 1) over a valid/ready handshake, tagging window and job boundaries.
- Throttles against the writer's progress in streaming mode, so no pixel is read before it is written.

Parameters:
DATA_WIDTH, 16, pixel width
ADDRESSWIDTH_F_PAD, 8, feature pad address width
ADDRESSWIDTH_W_PAD, 8, weight count width
OUT_FIFO_DEPTH_WIDTH, 2, log2 depth of output buffer (4 entries)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
read_start  in  1  one-cycle start pulse; ignored while busy
stream_mode  in  1  1 = gate reads on wr_addr; 0 = pad fully loaded
pixel_point  in  ADDRESSWIDTH_F_PAD  base address of the first column
out_num  in  ADDRESSWIDTH_F_PAD  number of output positions
weight_num  in  ADDRESSWIDTH_W_PAD  taps per window
wr_addr  in  ADDRESSWIDTH_F_PAD  writer's next write address (exclusive bound)
pad_rdata  in  DATA_WIDTH  registered pad output
raddra_ifmap  out  ADDRESSWIDTH_F_PAD  pad read address (registered)
fmap_to_pe  out  DATA_WIDTH  pixel to MAC
fmap_valid  out  1  fmap_to_pe valid
pe_ready  in  1  MAC accepts when fmap_valid & pe_ready
fmap_last_k  out  1  pixel is the last tap of its window
fmap_last  out  1  pixel is the final pixel of the job
busy  out  1  job in progress
read_done  out  1  one-cycle pulse when the last pixel is accepted

Behaviour:
- Reset: all outputs 0, raddra_ifmap 0, FSM IDLE, counters and buffer cleared.
- Reset asserted mid-job aborts the job immediately; no read_done is produced.
- Latching a job: read_start in IDLE latches all job inputs, sets busy, clears o_cnt/k_cnt, and enters READ.
- Degenerate jobs: if out_num==0 or weight_num==0, no reads are issued; read_done pulses on the next cycle and the FSM returns to IDLE.
- Read address: rd_addr = pixel_point + o_cnt + k_cnt, truncated to ADDRESSWIDTH_F_PAD bits, so it wraps modulo 2^ADDRESSWIDTH_F_PAD.
- Issue condition in READ: credit available AND (!stream_mode OR rd_addr < wr_addr, unsigned compare).
- Credit: buffer occupancy + reads in flight ≤ 3, with a 4-entry buffer.
- Issue timing:
  - On issue at edge t, raddra_ifmap <= rd_addr and the in-flight tag (last_k, last) is registered.
  - The pad samples the address in cycle t+1; pad_rdata is valid in cycle t+2.
  - The pixel is written to the buffer at edge t+2.
  - Fixed issue-to-fmap_valid latency is 3 cycles when the buffer is empty.
- Counter stepping: after each issue, k_cnt increments.
  - When k_cnt==weight_num-1: k_cnt<=0, o_cnt++, and the tag last_k=1.
  - The final issue (o_cnt==out_num-1 and k_cnt==weight_num-1) sets last=1 and moves the FSM to DRAIN.
- States:
  - IDLE: wait for read_start.
  - READ: issue reads.
  - DRAIN: wait until the buffer is empty and nothing is in flight.
  - Leaving DRAIN: read_done pulses in the cycle the last pixel is accepted, and busy falls on the following edge.
- Output handshake:
  - fmap_valid = buffer not empty.
  - fmap_to_pe, fmap_last_k and fmap_last are held stable while fmap_valid & !pe_ready.
  - pe_ready low never drops or duplicates data.
- Stall behaviour: a stream_mode stall, where wr_addr has not advanced, holds the counters and leaves raddra_ifmap unchanged.
- Simultaneous buffer push and pop in one cycle is legal; occupancy is unchanged.

Decomposition:
- Shared package:
  - FSM state encodings: IDLE=2'b00, READ=2'b01, DRAIN=2'b11.
  - Credit limit constant.
  - Address/weight width constants shared with the loader.
- One sub-module: the existing codebase fifo (DEPTH_WIDTH=OUT_FIFO_DEPTH_WIDTH, DATA_WIDTH=DATA_WIDTH+2). It carries the data plus the last_k and last tags, and serves as the output buffer.

Test Plan:
- Basic full-pad job: stream_mode=0, pixel_point=0, out_num=3, weight_num=3, pe_ready=1.
  - Expected: raddra_ifmap sequence 0,1,2,1,2,3,2,3,4.
  - fmap_last_k on beats 3, 6 and 9; fmap_last and read_done on beat 9.
  - First fmap_valid 3 cycles after the first issue.
- Backpressure: same job with pe_ready toggling 1,0,0,1 repeatedly.
  - Expected: identical data and tag sequence.
  - Outputs are held while fmap_valid & !pe_ready.
  - Occupancy + in-flight never exceeds 3.
- Writer gating: stream_mode=1, wr_addr=2, then stepped by 1 every 5 cycles.
  - Expected: no issue with rd_addr ≥ wr_addr.
  - The job completes only after wr_addr reaches 5.
- Address wrap: pixel_point=254, out_num=2, weight_num=2.
  - Expected: addresses 254, 255, 255, 0.
- Degenerate job and ignored start:
  - weight_num=0: read_done one cycle after read_start, no raddra_ifmap change.
  - A second read_start during a busy job is ignored.
- Reset mid-job: assert rst_n low during READ.
  - Expected: outputs cleared asynchronously, no read_done.
  - A fresh job afterwards runs correctly.
